// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-ready wait handshake and wait-timeout watchdog.
// Optional macro BNE_EN adds bne (opcode 000101) through the BRANCH state with branch_ne asserted.
module multicycle_ctrl #(
   parameter int ALUOPW   = 2,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        opcode,
   input  logic              mem_ready,
   output logic              pcwrite,
   output logic              pcwritecond,
   output logic              iord,
   output logic              memread,
   output logic              memwrite,
   output logic              irwrite,
   output logic              memtoreg,
   output logic              regdest,
   output logic              regwrite,
   output logic              alusrca,
   output logic [1:0]        alusrcb,
   output logic [ALUOPW-1:0] aluop,
   output logic [1:0]        pcsource,
   output logic [3:0]        state,
   output logic              illegal_op,
   output logic              mem_timeout,
   output logic              branch_ne
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [3:0]       cur_state;
   logic [3:0]       nxt_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             wait_state;
   logic             timeout;
   logic [1:0]       alu_ctl;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
`ifdef BNE_EN
         OP_BNE: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   assign state      = cur_state;
   assign wait_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
   // mem_ready arriving on the final allowed cycle still completes normally
   assign timeout    = wait_state && !mem_ready && (wait_cnt == CNT_W'(MAX_WAIT));
   assign aluop      = ALUOPW'(alu_ctl);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= S_FETCH;
         wait_cnt  <= '0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_cnt_nxt;
      end
   end

   always_comb begin
      nxt_state = S_FETCH;
      case (cur_state)
         S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:         nxt_state = S_EXEC;
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_BEQ:       nxt_state = S_BRANCH;
`ifdef BNE_EN
               OP_BNE:       nxt_state = S_BRANCH;
`endif
               OP_J:         nxt_state = S_JUMP;
               OP_ADDI:      nxt_state = S_ADDIEX;
               default:      nxt_state = S_FETCH;
            endcase
         end
         S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  nxt_state = S_FETCH;
         S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt_state = S_RWB;
         S_RWB:    nxt_state = S_FETCH;
         S_BRANCH: nxt_state = S_FETCH;
         S_JUMP:   nxt_state = S_FETCH;
         S_ADDIEX: nxt_state = S_ADDIWB;
         S_ADDIWB: nxt_state = S_FETCH;
         default:  nxt_state = S_FETCH;
      endcase
      if (timeout) nxt_state = S_FETCH;

      // Counter tracks only an unbroken run of not-ready cycles in one wait state
      if (timeout || mem_ready || !wait_state || (nxt_state != cur_state))
         wait_cnt_nxt = '0;
      else
         wait_cnt_nxt = wait_cnt + CNT_W'(1);
   end

   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdest     = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      alu_ctl     = 2'b00;
      pcsource    = 2'b00;
      illegal_op  = 1'b0;
      mem_timeout = timeout;
      branch_ne   = 1'b0;
      case (cur_state)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            illegal_op = !op_legal(opcode);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            alu_ctl = 2'b10;
         end
         S_RWB: begin
            regwrite = 1'b1;
            regdest  = 1'b1;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            alu_ctl     = 2'b01;
            pcwritecond = 1'b1;
            pcsource    = 2'b01;
`ifdef BNE_EN
            branch_ne   = (opcode == OP_BNE);
`endif
         end
         S_JUMP: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         default: ;
      endcase
      // An expired wait cancels the access it was waiting on
      if (timeout) begin
         memread  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         pcwrite  = 1'b0;
      end
      if (reset) begin
         pcwrite     = 1'b0;
         pcwritecond = 1'b0;
         iord        = 1'b0;
         memread     = 1'b0;
         memwrite    = 1'b0;
         irwrite     = 1'b0;
         memtoreg    = 1'b0;
         regdest     = 1'b0;
         regwrite    = 1'b0;
         alusrca     = 1'b0;
         alusrcb     = 2'b00;
         alu_ctl     = 2'b00;
         pcsource    = 2'b00;
         illegal_op  = 1'b0;
         mem_timeout = 1'b0;
         branch_ne   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle state/outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdest, regwrite, alusrca;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] state;
   logic       illegal_op, mem_timeout, branch_ne;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
      .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .branch_ne(branch_ne)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] F = 4'd0, D = 4'd1, MADR = 4'd2, MRD = 4'd3, MWB = 4'd4, MWR = 4'd5;
   localparam logic [3:0] EX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9, AEX = 4'd10, AWB = 4'd11;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BNE = 6'b000101, OP_BAD = 6'b111111;

   // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdest,regwrite,alusrca},
   // alusrcb, aluop, pcsource, {illegal_op,mem_timeout,branch_ne}
   localparam logic [18:0] O_ZERO     = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_FETCH    = {10'b1001010000, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_FETCH_NR = {10'b0001000000, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_FETCH_TO = {10'b0000000000, 2'b01, 2'b00, 2'b00, 3'b010};
   localparam logic [18:0] O_DECODE   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_DEC_ILL  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b100};
   localparam logic [18:0] O_MEMADR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_MEMRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_MEMWB    = {10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_MEMWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_EXEC     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 3'b000};
   localparam logic [18:0] O_RWB      = {10'b0000000110, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_BRANCH   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b000};
   localparam logic [18:0] O_BNE      = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b001};
   localparam logic [18:0] O_JUMP     = {10'b1000000000, 2'b00, 2'b00, 2'b10, 3'b000};
   localparam logic [18:0] O_ADDIEX   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
   localparam logic [18:0] O_ADDIWB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 3'b000};

   typedef struct {
      string       tag;
      logic [22:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [22:0] actual();
      return {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
              regdest, regwrite, alusrca, alusrcb, aluop, pcsource,
              illegal_op, mem_timeout, branch_ne};
   endfunction

   task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: state/outputs got %h expected %h (time %0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input string tag, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [18:0] o);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = mr;
      exp_q.push_back('{tag, {st, o}});
   endtask

   // Monitor: compare whatever the DUT presents against the oldest pending expectation
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, actual(), e.vec);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
      $fatal(1, "time limit");
   end

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = OP_R;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", actual(), {F, O_ZERO});
      mem_ready = 1'b0;
      reset     = 1'b0;
      exp_q.push_back('{"rst_release", {F, O_FETCH_NR}});

      // Zero-wait instruction mix
      step("rtype", OP_R, 1, F, O_FETCH);
      step("rtype", OP_R, 1, D, O_DECODE);
      step("rtype", OP_R, 1, EX, O_EXEC);
      step("rtype", OP_R, 1, RWB, O_RWB);
      step("lw", OP_LW, 1, F, O_FETCH);
      step("lw", OP_LW, 1, D, O_DECODE);
      step("lw", OP_LW, 1, MADR, O_MEMADR);
      step("lw", OP_LW, 1, MRD, O_MEMRD);
      step("lw", OP_LW, 1, MWB, O_MEMWB);
      step("sw", OP_SW, 1, F, O_FETCH);
      step("sw", OP_SW, 1, D, O_DECODE);
      step("sw", OP_SW, 1, MADR, O_MEMADR);
      step("sw", OP_SW, 1, MWR, O_MEMWR);
      step("beq", OP_BEQ, 1, F, O_FETCH);
      step("beq", OP_BEQ, 1, D, O_DECODE);
      step("beq", OP_BEQ, 1, BR, O_BRANCH);
      step("j", OP_J, 1, F, O_FETCH);
      step("j", OP_J, 1, D, O_DECODE);
      step("j", OP_J, 1, JP, O_JUMP);
      step("addi", OP_ADDI, 1, F, O_FETCH);
      step("addi", OP_ADDI, 1, D, O_DECODE);
      step("addi", OP_ADDI, 1, AEX, O_ADDIEX);
      step("addi", OP_ADDI, 1, AWB, O_ADDIWB);

      // lw with three wait states in MEMRD
      step("lw_wait", OP_LW, 1, F, O_FETCH);
      step("lw_wait", OP_LW, 1, D, O_DECODE);
      step("lw_wait", OP_LW, 1, MADR, O_MEMADR);
      for (int i = 0; i < 3; i++) step("lw_wait", OP_LW, 0, MRD, O_MEMRD);
      step("lw_wait", OP_LW, 1, MRD, O_MEMRD);
      step("lw_wait", OP_LW, 1, MWB, O_MEMWB);

      // Fetch starved twice in a row: timeout on the 16th cycle, then counter restarts from 0
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 15; i++) step("fetch_starve", OP_R, 0, F, O_FETCH_NR);
         step("fetch_timeout", OP_R, 0, F, O_FETCH_TO);
      end

      // mem_ready arrives on the final allowed MEMWR cycle
      step("sw_edge", OP_SW, 1, F, O_FETCH);
      step("sw_edge", OP_SW, 1, D, O_DECODE);
      step("sw_edge", OP_SW, 1, MADR, O_MEMADR);
      for (int i = 0; i < 15; i++) step("sw_edge_wait", OP_SW, 0, MWR, O_MEMWR);
      step("sw_edge_done", OP_SW, 1, MWR, O_MEMWR);
      step("sw_edge_next", OP_BAD, 1, F, O_FETCH);

      // Illegal opcode
      step("illegal", OP_BAD, 1, D, O_DEC_ILL);
      step("illegal_next", OP_BNE, 1, F, O_FETCH);

      // bne with and without the optional feature
`ifdef BNE_EN
      step("bne", OP_BNE, 1, D, O_DECODE);
      step("bne", OP_BNE, 1, BR, O_BNE);
`else
      step("bne_illegal", OP_BNE, 1, D, O_DEC_ILL);
`endif
      step("bne_next", OP_SW, 1, F, O_FETCH);

      // Asynchronous reset in the middle of a MEMWR wait
      step("rst_sw", OP_SW, 1, D, O_DECODE);
      step("rst_sw", OP_SW, 1, MADR, O_MEMADR);
      step("rst_sw", OP_SW, 0, MWR, O_MEMWR);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("rst_async", actual(), {F, O_ZERO});
      @(posedge clk);
      #1;
      check("rst_async_hold", actual(), {F, O_ZERO});
      mem_ready = 1'b0;
      reset     = 1'b0;
      exp_q.push_back('{"rst_refetch", {F, O_FETCH_NR}});
      step("rst_refetch", OP_R, 0, F, O_FETCH_NR);
      step("rst_refetch", OP_R, 1, F, O_FETCH);
      step("rst_refetch", OP_R, 1, D, O_DECODE);
      step("rst_refetch", OP_R, 1, EX, O_EXEC);
      step("rst_refetch", OP_R, 1, RWB, O_RWB);

      @(negedge clk);
      #1;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control unit. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states.
- Sits beside the shared-memory multi-cycle datapath and drives its mux selects and write strobes.
- Extends single-cycle decode with:
  - per-state sequencing;
  - a memory-ready wait handshake;
  - a wait-timeout watchdog;
  - parametrised aluop width and timeout depth.

Parameters:
- ALUOPW, 2, width of aluop; upper bits beyond [1:0] are driven 0.
- MAX_WAIT, 15, maximum consecutive cycles a memory state waits for mem_ready before timeout (must be ≥1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- opcode  input  6  instruction[31:26] from the instruction register
- mem_ready  input  1  memory completes the current access this cycle
- pcwrite  output  1  unconditional PC load
- pcwritecond  output  1  PC load if ALU zero (beq)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  instruction register load
- memtoreg  output  1  register write data select: 1=MDR
- regdest  output  1  destination register select: 1=rd
- regwrite  output  1  register file write
- alusrca  output  1  ALU A select: 0=PC, 1=A
- alusrcb  output  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- aluop  output  ALUOPW  00=add, 01=sub, 10=funct
- pcsource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- state  output  4  current state encoding (debug)
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_timeout  output  1  one-cycle pulse when a memory wait expires

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
  - Codes 12-15 are unused and go to FETCH on the next edge.
- Reset:
  - state=FETCH and wait counter=0, asynchronously.
  - While reset is high, every strobe is forced 0: pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite, illegal_op, mem_timeout.
  - All selects (iord, memtoreg, regdest, alusrca, alusrcb, aluop, pcsource) read 0 during reset.
  - Reset mid-instruction abandons that instruction with no further writes.
- Outputs are combinational from state only, except irwrite/pcwrite in FETCH, which are also gated by mem_ready. Unlisted outputs are 0.
- Per-state outputs and transitions:
  - FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready. Go to DECODE when mem_ready=1, else hold.
  - DECODE: alusrcb=11, aluop=00. Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - any other opcode -> FETCH, with illegal_op=1 this cycle.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD if opcode=100011, else MEMWR.
  - MEMRD: memread=1, iord=1. Go to MEMWB on mem_ready, else hold.
  - MEMWB: regwrite=1, memtoreg=1, regdest=0. Go to FETCH.
  - MEMWR: memwrite=1, iord=1. Go to FETCH on mem_ready, else hold.
  - EXEC: alusrca=1, alusrcb=00, aluop=10. Go to RWB.
  - RWB: regwrite=1, regdest=1, memtoreg=0. Go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Go to FETCH.
  - JUMP: pcwrite=1, pcsource=10. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regwrite=1, regdest=0, memtoreg=0. Go to FETCH.
- Latency with zero wait states (FETCH completes in 1 cycle):
  - R-type: 4 cycles
  - addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Wait counter and watchdog:
  - Counts consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - When the counter equals MAX_WAIT and mem_ready is still 0:
    - mem_timeout=1 for that cycle and no strobe fires;
    - the next state is FETCH and the counter clears.
  - If mem_ready=1 in the same cycle the counter reaches MAX_WAIT, mem_ready wins: normal transition, no timeout.
- opcode is sampled only in DECODE and MEMADR; it must be stable from DECODE until FETCH is re-entered.

Optional Feature:
- Macro BNE_EN.
- Defined:
  - opcode 000101 in DECODE -> BRANCH;
  - in BRANCH, output branch_ne=1 when opcode=000101, so the datapath inverts the zero condition;
  - 000101 does not raise illegal_op.
- Undefined:
  - branch_ne is tied to 0;
  - 000101 is illegal (illegal_op pulses, return to FETCH).
- The branch_ne port (output, 1 bit) exists in both builds.

Test Plan:
- Reset asserted mid-MEMWR, asynchronously between edges -> state=0 immediately; memwrite=0 in that cycle and after; first FETCH after release has pcwrite=0 until mem_ready=1.
- mem_ready=1 always; opcodes 000000, 100011, 101011, 000100, 000010, 001000 in turn -> cycle counts 4, 5, 4, 3, 3, 4; each state's outputs match the table exactly.
- lw with mem_ready held low 3 cycles in MEMRD, then high -> MEMRD occupied 4 cycles; single regwrite pulse in MEMWB; no mem_timeout.
- MAX_WAIT=15, mem_ready low forever in FETCH -> mem_timeout pulses on the 16th FETCH cycle; irwrite never 1; FETCH re-entered with the counter cleared.
- mem_ready rises exactly on the MAX_WAIT cycle in MEMWR -> memwrite completes; no mem_timeout; next state FETCH.
- opcode 111111 in DECODE -> illegal_op high for 1 cycle; no write strobes; next state FETCH. Opcode 000101 with and without BNE_EN -> BRANCH with branch_ne=1, or illegal_op, respectively.
